// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port round-robin arbiter and three-stage access sequencer
//             (grant / access / response) sharing one datamemory port between
//             the core load/store unit (port 0) and a secondary master
//             (port 1). Sustains one access per cycle, latency 2 from grant
//             to done.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset_n                 clock (rising edge), async active-low reset
//    pN_req/we/addr/wdata/funct3  port N request and its access fields
//    pN_gnt                       combinational grant (request accepted)
//    pN_done/rdata/err            registered completion pulse, load data,
//                                 misalign error (data/err zero when idle)
//    MemRead, MemWrite, a, wd,    datamemory control/address/data/size
//    Funct3
//    rd                           datamemory combinational read data
// ----------------------------------------------------------------------------
//  Configuration macro
//    DMEM_ARB_MISALIGN_CHK_EN  when defined, misaligned halfword/word
//                              accesses are suppressed at the memory and
//                              complete with pN_err = 1, pN_rdata = 0.
// ============================================================================
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // port 0
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [2:0]            p0_funct3,
  output logic                  p0_gnt,
  output logic                  p0_done,
  output logic [DATA_W-1:0]     p0_rdata,
  output logic                  p0_err,
  // port 1
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [2:0]            p1_funct3,
  output logic                  p1_gnt,
  output logic                  p1_done,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  p1_err,
  // datamemory
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  // Round-robin pointer: port that wins the next tie.
  logic rr;

  // Stage G: grant decision and selected request fields
  logic                  grant0;
  logic                  grant1;
  logic                  any_grant;
  logic                  sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [2:0]            sel_funct3;
  logic                  misalign;

  // Stage A: access registers
  logic                  acc_valid;
  logic                  acc_port;
  logic                  acc_we;
  logic [DM_ADDRESS-1:0] acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [2:0]            acc_funct3;
  logic                  acc_err;
  logic                  mem_rd;
  logic                  mem_wr;

  // Grants are forced low during reset so nothing is accepted while the
  // pipeline is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (p0_req && (!p1_req || !rr)) begin
        grant0 = 1'b1;
      end else if (p1_req) begin
        grant1 = 1'b1;
      end
    end
  end

  assign any_grant  = grant0 | grant1;
  assign p0_gnt     = grant0;
  assign p1_gnt     = grant1;

  assign sel_we     = grant1 ? p1_we     : p0_we;
  assign sel_addr   = grant1 ? p1_addr   : p0_addr;
  assign sel_wdata  = grant1 ? p1_wdata  : p0_wdata;
  assign sel_funct3 = grant1 ? p1_funct3 : p0_funct3;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  // Halfword (signed/unsigned) needs addr[0]=0, word needs addr[1:0]=0.
  always_comb begin
    misalign = 1'b0;
    case (sel_funct3)
      3'b001, 3'b101: misalign = sel_addr[0];
      3'b010:         misalign = |sel_addr[1:0];
      default:        misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Stage G -> A: capture the winner. The access registers only load on a
  // grant; acc_valid alone qualifies them, so stale contents are harmless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr         <= 1'b0;
      acc_valid  <= 1'b0;
      acc_port   <= 1'b0;
      acc_we     <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      acc_funct3 <= 3'b000;
      acc_err    <= 1'b0;
    end else begin
      acc_valid <= any_grant;
      if (any_grant) begin
        // Point at the port that lost (or was absent) this time.
        rr         <= grant0;
        acc_port   <= grant1;
        acc_we     <= sel_we;
        acc_addr   <= sel_addr;
        acc_wdata  <= sel_wdata;
        acc_funct3 <= sel_funct3;
        acc_err    <= misalign;
      end
    end
  end

  // Stage A: drive datamemory. A flagged access still occupies the slot but
  // never touches memory.
  assign mem_rd   = acc_valid & ~acc_we & ~acc_err;
  assign mem_wr   = acc_valid &  acc_we & ~acc_err;
  assign MemRead  = mem_rd;
  assign MemWrite = mem_wr;
  assign a        = acc_valid ? acc_addr   : '0;
  assign wd       = acc_valid ? acc_wdata  : '0;
  assign Funct3   = acc_valid ? acc_funct3 : 3'b000;

  // Stage A -> R: per-port response registers. Data and error are zero
  // whenever the port does not own the completing access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_done  <= 1'b0;
      p0_rdata <= '0;
      p0_err   <= 1'b0;
      p1_done  <= 1'b0;
      p1_rdata <= '0;
      p1_err   <= 1'b0;
    end else begin
      p0_done  <= acc_valid & ~acc_port;
      p0_rdata <= (mem_rd & ~acc_port) ? rd : '0;
      p0_err   <= acc_valid & ~acc_port & acc_err;
      p1_done  <= acc_valid & acc_port;
      p1_rdata <= (mem_rd & acc_port) ? rd : '0;
      p1_err   <= acc_valid & acc_port & acc_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a small
//             behavioural datamemory (falling-edge write, combinational
//             read with RISC-V size/sign handling).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        p0_req, p0_we, p0_gnt, p0_done, p0_err;
  logic [8:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic [2:0]  p0_funct3;
  logic        p1_req, p1_we, p1_gnt, p1_done, p1_err;
  logic [8:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic [2:0]  p1_funct3;
  logic        MemRead, MemWrite;
  logic [8:0]  a;
  logic [31:0] wd, rd;
  logic [2:0]  Funct3;

  int checks = 0;
  int errors = 0;
  int n0, n1;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_funct3(p0_funct3), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_funct3(p1_funct3), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd),
    .Funct3(Funct3), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datamemory
  logic [7:0] mem [512];
  logic [8:0] a1, a2, a3;
  assign a1 = a + 9'd1;
  assign a2 = a + 9'd2;
  assign a3 = a + 9'd3;

  always @(negedge clk) begin
    if (MemWrite) begin
      case (Funct3[1:0])
        2'b00: mem[a] <= wd[7:0];
        2'b01: begin mem[a] <= wd[7:0]; mem[a1] <= wd[15:8]; end
        default: begin
          mem[a]  <= wd[7:0];   mem[a1] <= wd[15:8];
          mem[a2] <= wd[23:16]; mem[a3] <= wd[31:24];
        end
      endcase
    end
  end

  always_comb begin
    rd = 32'd0;
    case (Funct3)
      3'b000:  rd = {{24{mem[a][7]}}, mem[a]};
      3'b001:  rd = {{16{mem[a1][7]}}, mem[a1], mem[a]};
      3'b100:  rd = {24'd0, mem[a]};
      3'b101:  rd = {16'd0, mem[a1], mem[a]};
      default: rd = {mem[a3], mem[a2], mem[a1], mem[a]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req0(input logic we, input logic [8:0] ad, input logic [31:0] d, input logic [2:0] f3);
    p0_req = 1'b1; p0_we = we; p0_addr = ad; p0_wdata = d; p0_funct3 = f3;
  endtask

  task automatic req1(input logic we, input logic [8:0] ad, input logic [31:0] d, input logic [2:0] f3);
    p1_req = 1'b1; p1_we = we; p1_addr = ad; p1_wdata = d; p1_funct3 = f3;
  endtask

  task automatic idle0();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_funct3 = '0;
  endtask

  task automatic idle1();
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_funct3 = '0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    reset_n = 1'b0;
    idle0();
    idle1();

    // Reset with a pending request: nothing granted, everything idle
    cyc(); cyc();
    req0(1'b0, 9'h000, 32'd0, 3'b010);
    settle();
    check("rst_gnt0",     32'(p0_gnt),   32'd0);
    check("rst_gnt1",     32'(p1_gnt),   32'd0);
    check("rst_memread",  32'(MemRead),  32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_a",        32'(a),        32'd0);
    check("rst_done0",    32'(p0_done),  32'd0);
    check("rst_rdata0",   p0_rdata,      32'd0);
    check("rst_err0",     32'(p0_err),   32'd0);

    cyc(); reset_n = 1'b1; settle();
    check("first_gnt0", 32'(p0_gnt), 32'd1);
    cyc(); idle0(); settle();
    check("first_memread", 32'(MemRead), 32'd1);
    check("first_done0_early", 32'(p0_done), 32'd0);
    cyc(); settle();
    check("first_done0", 32'(p0_done), 32'd1);
    check("first_rdata0", p0_rdata, 32'd0);
    check("idle_memread", 32'(MemRead), 32'd0);
    check("idle_a", 32'(a), 32'd0);
    check("idle_wd", wd, 32'd0);

    // P0 SW then P1 LW same address
    cyc(); req0(1'b1, 9'h010, 32'hDEADBEEF, 3'b010); settle();
    check("sw_gnt0", 32'(p0_gnt), 32'd1);
    cyc(); idle0(); req1(1'b0, 9'h010, 32'd0, 3'b010); settle();
    check("lw_gnt1", 32'(p1_gnt), 32'd1);
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    check("sw_memread", 32'(MemRead), 32'd0);
    check("sw_a", 32'(a), 32'h010);
    check("sw_wd", wd, 32'hDEADBEEF);
    check("sw_funct3", 32'(Funct3), 32'd2);
    cyc(); idle1(); settle();
    check("sw_done0", 32'(p0_done), 32'd1);
    check("sw_done1", 32'(p1_done), 32'd0);
    check("lw_memread", 32'(MemRead), 32'd1);
    cyc(); settle();
    check("lw_done1", 32'(p1_done), 32'd1);
    check("lw_rdata1", p1_rdata, 32'hDEADBEEF);
    check("lw_err1", 32'(p1_err), 32'd0);
    check("lw_done0", 32'(p0_done), 32'd0);
    cyc(); settle();
    check("lw_done1_off", 32'(p1_done), 32'd0);
    check("lw_rdata1_off", p1_rdata, 32'd0);

    // Both ports requesting for 6 cycles: grants 0,1,0,1,0,1
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i < 6) begin
        req0(1'b0, 9'h010, 32'd0, 3'b010);
        req1(1'b0, 9'h000, 32'd0, 3'b010);
      end else begin
        idle0(); idle1();
      end
      settle();
      if (i < 6) begin
        check("rr_gnt0", 32'(p0_gnt), 32'(i % 2 == 0));
        check("rr_gnt1", 32'(p1_gnt), 32'(i % 2 == 1));
      end
      if (i >= 2) begin
        check("rr_done0", 32'(p0_done), 32'(i % 2 == 0));
        check("rr_done1", 32'(p1_done), 32'(i % 2 == 1));
        if (p0_done) begin
          n0++;
          check("rr_rdata0", p0_rdata, 32'hDEADBEEF);
        end
        if (p1_done) n1++;
      end
    end
    check("rr_count0", 32'(n0), 32'd3);
    check("rr_count1", 32'(n1), 32'd3);

    // SB 0x80 to 0x005, then LB and LBU back-to-back
    cyc(); req0(1'b1, 9'h005, 32'h00000080, 3'b000); settle();
    cyc(); req0(1'b0, 9'h005, 32'd0, 3'b000); settle();
    cyc(); req0(1'b0, 9'h005, 32'd0, 3'b100); settle();
    check("sb_done0", 32'(p0_done), 32'd1);
    cyc(); idle0(); settle();
    check("lb_done0", 32'(p0_done), 32'd1);
    check("lb_rdata0", p0_rdata, 32'hFFFFFF80);
    cyc(); settle();
    check("lbu_done0", 32'(p0_done), 32'd1);
    check("lbu_rdata0", p0_rdata, 32'h00000080);

    // Reset in the access cycle of a store drops it
    cyc(); req0(1'b1, 9'h020, 32'h11223344, 3'b010); settle();
    cyc(); idle0(); settle();
    cyc(); cyc();
    cyc(); req0(1'b1, 9'h020, 32'hAAAAAAAA, 3'b010); settle();
    check("rstacc_gnt0", 32'(p0_gnt), 32'd1);
    cyc(); idle0(); reset_n = 1'b0; settle();
    check("rstacc_memwrite", 32'(MemWrite), 32'd0);
    cyc(); settle();
    check("rstacc_done0_a", 32'(p0_done), 32'd0);
    cyc(); reset_n = 1'b1; settle();
    check("rstacc_done0_b", 32'(p0_done), 32'd0);
    cyc(); req0(1'b0, 9'h020, 32'd0, 3'b010); settle();
    check("rstacc_done0_c", 32'(p0_done), 32'd0);
    cyc(); idle0(); settle();
    cyc(); settle();
    check("rstlw_done0", 32'(p0_done), 32'd1);
    check("rstlw_rdata0", p0_rdata, 32'h11223344);

    // P1 misaligned LW at 0x006
    cyc(); req1(1'b0, 9'h006, 32'd0, 3'b010); settle();
    check("mis_gnt1", 32'(p1_gnt), 32'd1);
    cyc(); idle1(); settle();
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    check("mis_memread", 32'(MemRead), 32'd0);
`else
    check("mis_memread", 32'(MemRead), 32'd1);
`endif
    cyc(); settle();
    check("mis_done1", 32'(p1_done), 32'd1);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    check("mis_err1", 32'(p1_err), 32'd1);
`else
    check("mis_err1", 32'(p1_err), 32'd0);
`endif
    check("mis_rdata1", p1_rdata, 32'd0);
    cyc(); settle();
    check("mis_err1_off", 32'(p1_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
